// File: rtl/d_m_areg_queue.sv
// Directory-to-memory flit queue: buffers up to DEPTH flits in arrival order and
// presents the oldest to the memory controller until it signals completion.
module d_m_areg_queue #(
    parameter int FLIT_W = 144,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] d_flits_m,
    input  logic              v_d_flits_m,
    input  logic              mem_done_access,
    output logic [FLIT_W-1:0] d_m_areg_flits,
    output logic              v_d_m_areg_flits,
    output logic              d_m_areg_state,
    output logic [CNT_W-1:0]  d_m_areg_count,
    output logic              d_m_areg_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;
    logic [CNT_W-1:0]  count;
    logic              err;

    logic empty;
    logic full;
    logic pop_ok;
    logic push_ok;
    logic err_event;

    // Occupancy alone decides full/empty, so wp == rp is never ambiguous.
    always_comb begin
        empty     = (count == '0);
        full      = (count == FULL_CNT);
        pop_ok    = mem_done_access && !empty;
        push_ok   = v_d_flits_m && (!full || pop_ok);
        err_event = (mem_done_access && empty) || (v_d_flits_m && !push_ok);
    end

    // NOTE: storage carries no reset; count gates every read, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wp] <= d_flits_m;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (push_ok) begin
                wp <= (wp == LAST_PTR) ? '0 : wp + PTR_W'(1);
            end
            if (pop_ok) begin
                rp <= (rp == LAST_PTR) ? '0 : rp + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
            if (err_event) begin
                err <= 1'b1;
            end
        end
    end

    // Head is driven from registers only; zeros whenever the queue is empty.
    always_comb begin
        d_m_areg_flits   = empty ? '0 : mem[rp];
        v_d_m_areg_flits = !empty;
        d_m_areg_state   = full;
        d_m_areg_count   = count;
        d_m_areg_err     = err;
    end

endmodule

// File: tb/tb_d_m_areg_queue.sv
// Bench for d_m_areg_queue: three instances (DEPTH 4, 3, 1) share one stimulus
// stream and are compared every cycle against a queue-based reference model.
module tb_d_m_areg_queue;

    localparam int FW = 144;

    logic          clk;
    logic          rst;
    logic [FW-1:0] d_flits_m;
    logic          v_d_flits_m;
    logic          mem_done_access;

    logic [FW-1:0] flits_w [3];
    logic          valid_w [3];
    logic          state_w [3];
    logic          err_w   [3];
    logic [2:0]    cnt_w   [3];
    logic [2:0]    cnt4;
    logic [1:0]    cnt3;
    logic [0:0]    cnt1;

    assign cnt_w[0] = cnt4;
    assign cnt_w[1] = {1'b0, cnt3};
    assign cnt_w[2] = {2'b0, cnt1};

    d_m_areg_queue #(.FLIT_W(FW), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .d_flits_m(d_flits_m), .v_d_flits_m(v_d_flits_m),
        .mem_done_access(mem_done_access), .d_m_areg_flits(flits_w[0]),
        .v_d_m_areg_flits(valid_w[0]), .d_m_areg_state(state_w[0]),
        .d_m_areg_count(cnt4), .d_m_areg_err(err_w[0])
    );

    d_m_areg_queue #(.FLIT_W(FW), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .d_flits_m(d_flits_m), .v_d_flits_m(v_d_flits_m),
        .mem_done_access(mem_done_access), .d_m_areg_flits(flits_w[1]),
        .v_d_m_areg_flits(valid_w[1]), .d_m_areg_state(state_w[1]),
        .d_m_areg_count(cnt3), .d_m_areg_err(err_w[1])
    );

    d_m_areg_queue #(.FLIT_W(FW), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .d_flits_m(d_flits_m), .v_d_flits_m(v_d_flits_m),
        .mem_done_access(mem_done_access), .d_m_areg_flits(flits_w[2]),
        .v_d_m_areg_flits(valid_w[2]), .d_m_areg_state(state_w[2]),
        .d_m_areg_count(cnt1), .d_m_areg_err(err_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one FIFO queue, depth and sticky error per instance.
    logic [FW-1:0] mq [3][$];
    bit            merr [3];
    int            dep [3] = '{4, 3, 1};

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit push, input bit pop, input logic [FW-1:0] data);
        for (int i = 0; i < 3; i++) begin
            int  sz;
            bit  pop_ok;
            bit  push_ok;
            sz      = mq[i].size();
            pop_ok  = pop && (sz != 0);
            push_ok = push && ((sz < dep[i]) || pop_ok);
            if (pop && sz == 0) merr[i] = 1'b1;
            if (push && !push_ok) merr[i] = 1'b1;
            if (pop_ok) void'(mq[i].pop_front());
            if (push_ok) mq[i].push_back(data);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            merr[i] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            int sz;
            sz = mq[i].size();
            check($sformatf("flits[d%0d]", dep[i]), flits_w[i], (sz != 0) ? mq[i][0] : '0);
            check($sformatf("valid[d%0d]", dep[i]), FW'(valid_w[i]), FW'(sz != 0));
            check($sformatf("state[d%0d]", dep[i]), FW'(state_w[i]), FW'(sz == dep[i]));
            check($sformatf("count[d%0d]", dep[i]), FW'(cnt_w[i]), FW'(sz));
            check($sformatf("err[d%0d]", dep[i]), FW'(err_w[i]), FW'(merr[i]));
        end
    endtask

    // One clock: drive on the falling edge, model on the rising edge, sample 1 ns later.
    task automatic cycle(input bit push, input bit pop, input logic [FW-1:0] data);
        @(negedge clk);
        v_d_flits_m     = push;
        mem_done_access = pop;
        d_flits_m       = data;
        @(posedge clk);
        model_step(push, pop, data);
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic mid_reset();
        @(negedge clk);
        v_d_flits_m     = 1'b0;
        mem_done_access = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [FW-1:0] rand_flit();
        return {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
    endfunction

    initial begin
        rst             = 1'b0;
        d_flits_m       = '0;
        v_d_flits_m     = 1'b0;
        mem_done_access = 1'b0;
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // Basic flow and fill to DEPTH=4.
        cycle(1'b1, 1'b0, FW'(1));
        check("planA_head", flits_w[0], FW'(1));
        check("planA_d1_full", FW'(state_w[2]), FW'(1));
        for (int k = 2; k <= 4; k++) cycle(1'b1, 1'b0, FW'(k));
        check("plan_fill_count", FW'(cnt_w[0]), FW'(4));
        check("plan_fill_state", FW'(state_w[0]), FW'(1));
        check("plan_d1_overflow_err", FW'(err_w[2]), FW'(1));

        // Overflow while full, then drain.
        cycle(1'b1, 1'b0, FW'(5));
        check("plan_ovf_err", FW'(err_w[0]), FW'(1));
        check("plan_ovf_head", flits_w[0], FW'(1));
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, '0);
        check("plan_drain_valid", FW'(valid_w[0]), FW'(0));

        // Simultaneous push/pop while full, then while empty.
        for (int k = 1; k <= 4; k++) cycle(1'b1, 1'b0, FW'(k));
        cycle(1'b1, 1'b1, FW'(5));
        check("plan_pp_full_head", flits_w[0], FW'(2));
        check("plan_pp_full_count", FW'(cnt_w[0]), FW'(4));
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, '0);
        cycle(1'b1, 1'b1, FW'(6));
        check("plan_pp_empty_head", flits_w[0], FW'(6));
        cycle(1'b0, 1'b1, '0);

        // Interleaved incrementing pattern crossing the pointer wrap.
        mid_reset();
        for (int k = 0; k < 10; k++) cycle(1'b1, (k % 3) != 0, FW'(100 + k));
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, '0);

        // Reset with two entries queued.
        cycle(1'b1, 1'b0, FW'(7));
        cycle(1'b1, 1'b0, FW'(8));
        mid_reset();
        check("plan_rst_count", FW'(cnt_w[0]), FW'(0));

        // Randomised traffic with occasional reset.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 149) == 0) begin
                mid_reset();
            end else begin
                cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, rand_flit());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
